// File: rtl/mms_pkg.sv
// -----------------------------------------------------------------------------
// mms_pkg
// Shared definitions for the sequential max/min scanner (mms_seq_ctrl) and its
// update-decision helper (mms_cmp_upd).
//
// Contents:
//   MMS_DATA_W  default operand/result width
//   SEL_MAX     select encoding for "frame maximum"
//   SEL_MIN     select encoding for "frame minimum"
//   state_e     controller state encoding (IDLE / LOAD / DONE)
// -----------------------------------------------------------------------------
package mms_pkg;

  localparam int MMS_DATA_W = 8;

  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for start
    LOAD = 2'd1,  // accepting operands
    DONE = 2'd2   // presenting result until the sink takes it
  } state_e;

endpackage : mms_pkg

// File: rtl/mms_cmp_upd.sv
// -----------------------------------------------------------------------------
// mms_cmp_upd
// Combinational accumulator-update decision for one max/min lane. A single
// unsigned "acc < in_data" comparator serves both directions.
//
// Ports:
//   acc      in   DATA_W  current accumulator (running max or min)
//   in_data  in   DATA_W  incoming operand
//   select   in   1       SEL_MAX / SEL_MIN
//   first    in   1       incoming operand is the first of the frame
//   upd_en   out  1       load in_data into the accumulator
//
// Tie policy: max keeps the earlier equal operand (strict less-than), min takes
// the later one (negated less-than is "greater or equal").
// -----------------------------------------------------------------------------
module mms_cmp_upd
  import mms_pkg::*;
#(
  parameter int DATA_W = MMS_DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              select,
  input  logic              first,
  output logic              upd_en
);

  logic acc_lt_in;

  // Both operands are unsigned and of equal width, so no width growth occurs.
  assign acc_lt_in = (acc < in_data);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves upd_en
    // unassigned; a missing default infers a latch.
    upd_en = 1'b0;
    if (first) begin
      upd_en = 1'b1;
    end else if (select == SEL_MAX) begin
      upd_en = acc_lt_in;
    end else begin
      upd_en = !acc_lt_in;
    end
  end

endmodule : mms_cmp_upd

// File: rtl/mms_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mms_seq_ctrl
// Sequential max/min scanner. Accepts a frame of NUM unsigned operands over a
// valid/ready stream and returns the frame maximum (select=0) or minimum
// (select=1), time-sharing one comparator and one accumulator register.
//
// Optional feature (macro MMS_IDX_EN): adds output result_idx, the 0-based
// arrival position of the winning operand. Without the macro the port and its
// register are absent and everything else behaves identically.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       begin a frame; only honoured in IDLE
//   select      in   1       0 = max, 1 = min; latched when start is taken
//   in_valid    in   1       in_data valid
//   in_ready    out  1       operand accepted this cycle when in_valid is high
//   in_data     in   DATA_W  operand
//   out_valid   out  1       result valid; held until out_ready
//   out_ready   in   1       sink takes the result
//   result      out  DATA_W  frame max/min
//   busy        out  1       frame in progress (LOAD or DONE)
//   result_idx  out  CNT_W   winner position (MMS_IDX_EN only)
// -----------------------------------------------------------------------------
module mms_seq_ctrl
  import mms_pkg::*;
#(
  parameter  int DATA_W = MMS_DATA_W,
  parameter  int NUM    = 8,
  localparam int CNT_W  = $clog2(NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              select,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
`ifdef MMS_IDX_EN
  ,
  output logic [CNT_W-1:0]  result_idx
`endif
);

  // A one-operand frame has nothing to compare and would make CNT_W zero.
  if (NUM < 2) begin : g_num_check
    $error("mms_seq_ctrl: NUM must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic                sel_q,       sel_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [DATA_W-1:0]   acc_q,       acc_d;
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q,      busy_d;
`ifdef MMS_IDX_EN
  logic [CNT_W-1:0]    idx_q,       idx_d;
`endif

  logic accept;     // operand handshake completes this cycle
  logic first_op;   // accepted operand is the first of the frame
  logic last_op;    // accepted operand is the last of the frame
  logic upd_en;     // accumulator takes in_data

  // in_ready_q is only ever high in LOAD, so it doubles as the state qualifier.
  assign accept   = in_valid && in_ready_q;
  assign first_op = (cnt_q == '0);
  assign last_op  = (cnt_q == CNT_W'(NUM - 1));

  mms_cmp_upd #(
    .DATA_W (DATA_W)
  ) u_cmp_upd (
    .acc     (acc_q),
    .in_data (in_data),
    .select  (sel_q),
    .first   (first_op),
    .upd_en  (upd_en)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`ifdef MMS_IDX_EN
    idx_d   = idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          sel_d   = select;
          cnt_d   = '0;
        end
      end

      // start and select are deliberately not looked at here: a frame in
      // progress runs to completion with the select latched at its start.
      LOAD: begin
        if (accept) begin
          if (upd_en) begin
            acc_d = in_data;
`ifdef MMS_IDX_EN
            idx_d = cnt_q;
`endif
          end
          if (last_op) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      // A start coinciding with the result handshake is dropped; the next
      // frame needs a start while already in IDLE.
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies decoded from the next state, so they
    // change exactly on the edge that enters or leaves a state.
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= SEL_MAX;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MMS_IDX_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MMS_IDX_EN
      idx_q       <= idx_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The accumulator does not move in DONE, so result is stable while the sink
  // applies backpressure.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;
`ifdef MMS_IDX_EN
  assign result_idx = idx_q;
`endif

endmodule : mms_seq_ctrl

// File: tb/tb_mms_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mms_seq_ctrl
// Directed self-checking bench for mms_seq_ctrl (DATA_W=8, NUM=8).
// Inputs are driven just after the falling edge and outputs are sampled at the
// falling edge, half a period away from the active rising edge.
// Winner-index checks apply only when MMS_IDX_EN is defined.
// -----------------------------------------------------------------------------
module tb_mms_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int NUM    = 8;
  localparam int CNT_W  = $clog2(NUM);

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              select;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              busy;
`ifdef MMS_IDX_EN
  logic [CNT_W-1:0]  result_idx;
`endif

  int total;
  int bad;

  logic [DATA_W-1:0] ops [NUM];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mms_seq_ctrl #(
    .DATA_W (DATA_W),
    .NUM    (NUM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
`ifdef MMS_IDX_EN
    ,
    .result_idx (result_idx)
`endif
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idx(input string tag, input int exp);
`ifdef MMS_IDX_EN
    check(tag, 32'(result_idx), 32'(exp));
`endif
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Pulse start for one cycle from IDLE; the block must be in LOAD afterwards.
  task automatic begin_frame(input string tag, input logic sel);
    start  = 1'b1;
    select = sel;
    cyc();
    start  = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_busy"},     32'(busy),     1);
  endtask

  // Present ops[lo..hi]; with gaps, in_valid drops for one cycle after each.
  task automatic send_ops(input string tag, input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      int n;
      n        = 0;
      in_data  = ops[i];
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
        cyc();
        n++;
      end
      if (!in_ready) check({tag, "_ready_wait"}, 32'(in_ready), 1);
      cyc();
      in_valid = 1'b0;
      if (gaps && i != NUM - 1) begin
        check({tag, "_no_early_done"}, 32'(out_valid), 0);
        cyc();
      end
    end
  endtask

  task automatic expect_done(input string tag, input int res, input int idx);
    check({tag, "_out_valid"}, 32'(out_valid), 1);
    check({tag, "_result"},    32'(result),    32'(res));
    check_idx({tag, "_idx"}, idx);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check({tag, "_ov_drop"},   32'(out_valid), 0);
    check({tag, "_idle_busy"}, 32'(busy),      0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    total     = 0;
    bad       = 0;
    start     = 1'b0;
    select    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;

    // Reset state
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_result",    32'(result),    0);
    check_idx("rst_idx", 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Max frame: 255 at position 5
    ops = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd0, 8'd255, 8'd9, 8'd1};
    begin_frame("max", 1'b0);
    check("max_ov_load", 32'(out_valid), 0);
    send_ops("max", 0, NUM - 1, 1'b0);
    expect_done("max", 255, 5);
    handshake("max");

    // Min frame with ties: latest 4 (position 4) wins
    ops = '{8'd50, 8'd4, 8'd90, 8'd4, 8'd4, 8'd77, 8'd120, 8'd8};
    begin_frame("min", 1'b1);
    send_ops("min", 0, NUM - 1, 1'b0);
    expect_done("min", 4, 4);
    handshake("min");

    // in_valid toggling, then output backpressure for 5 cycles
    for (int i = 0; i < NUM; i++) ops[i] = 8'(10 + i);
    begin_frame("stall", 1'b0);
    send_ops("stall", 0, NUM - 1, 1'b1);
    expect_done("stall", 17, 7);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_result",    32'(result),    17);
    end
    handshake("stall");

    // Protocol abuse: start + select flip mid-frame on a max frame of 1..8
    for (int i = 0; i < NUM; i++) ops[i] = 8'(1 + i);
    begin_frame("abuse", 1'b0);
    send_ops("abuse", 0, 2, 1'b0);
    start  = 1'b1;
    select = 1'b1;
    cyc();
    start  = 1'b0;
    check("abuse_still_load", 32'(in_ready), 1);
    send_ops("abuse", 3, NUM - 1, 1'b0);
    expect_done("abuse", 8, 7);
    start = 1'b1;                // start while DONE and not yet taken
    cyc();
    start = 1'b0;
    check("abuse_done_hold", 32'(out_valid), 1);
    start     = 1'b1;            // start coincident with the handshake
    out_ready = 1'b1;
    cyc();
    start     = 1'b0;
    out_ready = 1'b0;
    check("abuse_hs_ov",    32'(out_valid), 0);
    check("abuse_hs_ready", 32'(in_ready),  0);
    cyc();
    check("abuse_no_restart", 32'(busy), 0);
    select = 1'b0;

    // Asynchronous reset after three accepts
    ops = '{8'd100, 8'd50, 8'd70, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    begin_frame("arst", 1'b0);
    send_ops("arst", 0, 2, 1'b0);
    check("arst_pre_result", 32'(result), 100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_busy",      32'(busy),      0);
    check("arst_result",    32'(result),    0);
    check_idx("arst_idx", 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < NUM; i++) ops[i] = 8'd9;
    begin_frame("nines", 1'b1);
    send_ops("nines", 0, NUM - 1, 1'b0);
    expect_done("nines", 9, 7);
    handshake("nines");

    // Boundary values and back-to-back frames
    for (int i = 0; i < NUM; i++) ops[i] = 8'd0;
    begin_frame("zeros", 1'b0);
    send_ops("zeros", 0, NUM - 1, 1'b0);
    expect_done("zeros", 0, 0);
    handshake("zeros");

    for (int i = 0; i < NUM; i++) ops[i] = 8'd255;
    begin_frame("ones", 1'b1);
    send_ops("ones", 0, NUM - 1, 1'b0);
    expect_done("ones", 255, 7);
    handshake("ones");

    // Started the cycle after the previous handshake; max tie keeps earliest 9
    ops = '{8'd5, 8'd1, 8'd9, 8'd9, 8'd2, 8'd0, 8'd7, 8'd3};
    begin_frame("b2b", 1'b0);
    send_ops("b2b", 0, NUM - 1, 1'b0);
    expect_done("b2b", 9, 2);
    handshake("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mms_seq_ctrl

// File: doc/mms_seq_ctrl.md
Name: mms_seq_ctrl

Overview:
- Sequential max/min scanner: accepts a frame of NUM unsigned operands serially over a valid/ready stream and returns the frame maximum (select=0) or minimum (select=1).
- Time-shares one DATA_W comparator plus an accumulator register across the frame, instead of a combinational comparator tree.
- Sits between the operand source (testbench/host) and the result sink in the hw1 max/min selection path.

Parameters:
- DATA_W, 8: operand/result width, unsigned.
- NUM, 8: operands per frame, ≥2.
- CNT_W, $clog2(NUM): operand counter width, derived.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
- select  input  1  0 = maximum, 1 = minimum; sampled at accepted start, held internally for the frame.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_W  operand.
- out_valid  output  1  result valid, held until out_ready.
- out_ready  input  1  sink accepts result.
- result  output  DATA_W  frame max/min.
- busy  output  1  high in LOAD or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=0, out_valid=0, busy=0, result=0, accumulator=0, counter=0, latched select=0.
- States:
  - IDLE: start → LOAD; latch select; counter=0.
  - LOAD: in_ready=1. An operand is accepted on in_valid&&in_ready.
    - First operand (counter==0) loads the accumulator unconditionally.
    - Later operands replace the accumulator when:
      - max: acc < in_data;
      - min: NOT (acc < in_data), so on ties the later operand wins.
    - counter increments per accepted operand; the accept with counter==NUM-1 → DONE.
  - DONE: out_valid=1, result=accumulator. out_valid&&out_ready → IDLE the same edge; out_valid drops next cycle.
- Latency: result valid the cycle after the last operand is accepted. Minimum frame time is NUM+1 cycles plus the handshake cycle.
- in_valid low in LOAD: stall, no state change. No timeout.
- start while busy: ignored, no effect on the current frame.
- start coincident with out_valid&&out_ready: ignored; the new start must arrive in IDLE.
- select changing mid-frame: no effect, latched copy used.
- result stable while out_valid=1 and out_ready=0.
- Comparison is unsigned, DATA_W bits; no width growth.
- rst_n assertion mid-frame: immediate return to the reset values; partial frame discarded.

Optional Feature:
- Macro MMS_IDX_EN.
- Defined: extra output port result_idx [CNT_W-1:0] holding the 0-based arrival position of the winning operand. It updates whenever the accumulator updates, resets to 0, and is valid with out_valid. Tie policy as above: max keeps the earliest equal operand, min takes the latest.
- Undefined: port and index register absent; all other behaviour identical.

Decomposition:
- Shared package mms_pkg:
  - state enum IDLE/LOAD/DONE (2-bit);
  - SEL_MAX=1'b0, SEL_MIN=1'b1;
  - default DATA_W.
- One natural sub-module: mms_cmp_upd. It is combinational: given acc, in_data, select and first-flag, it produces the update-enable. This makes it reusable by a future multi-lane variant.
- FSM, counter and registers stay in the top.

Test Plan:
- Max frame: select=0, NUM=8, operands 3,200,17,200,0,255,9,1 with in_valid continuous → out_valid one cycle after the 8th accept, result=255 (idx=5).
- Min frame with ties: select=1, operands 50,4,90,4,4,77,120,8 → result=4 (idx=4).
- Stalls/backpressure:
  - in_valid toggles 1/0 every cycle, operands 10..17 → result=17 after 8 accepts; no extra counts.
  - out_ready held low 5 cycles → result stays 17 and out_valid stays high.
- Protocol abuse: start pulsed during LOAD, and select flipped mid-frame on a max frame of 1,2,...,8 → result=8; a second frame starts only after return to IDLE.
- Reset mid-frame: rst_n low asynchronously after 3 accepts → all outputs 0 immediately. Then a new min frame 9,9,9,9,9,9,9,9 → result=9 (idx=7).
- Boundary values: all-zero frame with max → 0; all-255 frame with min → 255; back-to-back frames with start issued the cycle after the handshake → both correct.
